// File: rtl/move_dda.sv
// move_dda: buffered step/dir generator using a phase-accumulator DDA.
// Optional per-tick increment ramping is enabled by defining ACCEL_EN.
module move_dda #(
    parameter int ACC_W     = 32,
    parameter int CNT_W     = 32,
    parameter int BUF_DEPTH = 2,
    parameter int TICK_DIV  = 1,
    parameter int STEP_HIGH = 4,
    parameter int DIR_SETUP = 2
) (
    input  logic             CLK,
    input  logic             resetn,
    input  logic             move_valid,
    output logic             move_ready,
    input  logic             move_dir,
    input  logic [CNT_W-1:0] move_steps,
    input  logic [ACC_W-1:0] move_inc,
`ifdef ACCEL_EN
    input  logic [ACC_W-1:0] move_incinc,
`endif
    input  logic             halt,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             move_done,
    output logic             buffer_dtr,
    output logic             overrun
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(STEP_HIGH + 1);
    localparam int SW = (DIR_SETUP > 0) ? $clog2(DIR_SETUP + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETUP, S_RUN, S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic             r_fdir   [BUF_DEPTH];
    logic [CNT_W-1:0] r_fsteps [BUF_DEPTH];
    logic [ACC_W-1:0] r_finc   [BUF_DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nx;
    logic             r_rdy;
    logic             w_wr;
    logic             w_pop;
    logic             w_empty;

    logic             w_hdir;
    logic [CNT_W-1:0] w_hsteps;
    logic [ACC_W-1:0] w_hinc;

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] w_inc_nx;
    logic [ACC_W:0]   w_sum;
    logic [CNT_W-1:0] r_rem;
    logic [DW-1:0]    r_div;
    logic [SW-1:0]    r_setup;
    logic [HW-1:0]    r_hcnt;
    logic             r_step;
    logic             r_dir;
    logic             r_ovr;
    logic             w_tick;
    logic             w_adv;
    logic             w_carry;
    logic             w_busy;
    logic             w_done;

    assign move_ready = r_rdy & ~halt;
    assign buffer_dtr = move_ready;
    assign step       = r_step;
    assign dir        = r_dir;
    assign overrun    = r_ovr;
    assign busy       = w_busy;
    assign move_done  = w_done;

    assign w_wr     = move_valid & move_ready;
    assign w_pop    = (r_state == S_LOAD) & ~halt;
    assign w_empty  = (r_cnt == '0);
    assign w_hdir   = r_fdir[r_rp];
    assign w_hsteps = r_fsteps[r_rp];
    assign w_hinc   = r_finc[r_rp];

    always_comb begin
        w_cnt_nx = r_cnt;
        if (w_wr && !w_pop) begin
            w_cnt_nx = r_cnt + CW'(1);
        end else if (!w_wr && w_pop) begin
            w_cnt_nx = r_cnt - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_fdir[r_wp]   <= move_dir;
            r_fsteps[r_wp] <= move_steps;
            r_finc[r_wp]   <= move_inc;
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_rdy <= 1'b0;
        end else if (halt) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_rdy <= 1'b1;
        end else begin
            if (w_wr) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_cnt <= w_cnt_nx;
            r_rdy <= (w_cnt_nx < CW'(BUF_DEPTH));
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE:  if (!w_empty) w_state_nx = S_LOAD;
            S_LOAD:  w_state_nx = (w_hsteps == '0) ? S_DONE : S_SETUP;
            S_SETUP: if (r_setup == '0) w_state_nx = S_RUN;
            S_RUN:   if (r_rem == '0 && !r_step) w_state_nx = S_DONE;
            S_DONE:  w_state_nx = w_empty ? S_IDLE : S_LOAD;
            default: w_state_nx = S_IDLE;
        endcase
        if (halt) w_state_nx = S_IDLE;
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
        w_done = (r_state == S_DONE);
    end

    assign w_tick  = (r_div == DW'(TICK_DIV - 1));
    assign w_adv   = (r_state == S_RUN) & w_tick & (r_rem != '0);
    assign w_sum   = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_carry = w_adv & w_sum[ACC_W];

`ifdef ACCEL_EN
    logic [ACC_W-1:0]        r_fincinc [BUF_DEPTH];
    logic [ACC_W-1:0]        r_incinc;
    logic signed [ACC_W+1:0] w_isum;

    always_ff @(posedge CLK) begin
        if (w_wr) r_fincinc[r_wp] <= move_incinc;
    end

    always_ff @(posedge CLK) begin
        if (!resetn)    r_incinc <= '0;
        else if (w_pop) r_incinc <= r_fincinc[r_rp];
    end

    // Signed ramp with clamping to the unsigned increment range
    always_comb begin
        w_isum = $signed({2'b00, r_inc})
               + $signed({{2{r_incinc[ACC_W-1]}}, r_incinc});
        if (w_isum < 0) begin
            w_inc_nx = '0;
        end else if (w_isum > $signed({2'b00, {ACC_W{1'b1}}})) begin
            w_inc_nx = '1;
        end else begin
            w_inc_nx = w_isum[ACC_W-1:0];
        end
    end
`else
    assign w_inc_nx = r_inc;
`endif

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            r_acc   <= '0;
            r_inc   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_setup <= '0;
            r_hcnt  <= '0;
            r_step  <= 1'b0;
            r_dir   <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (halt) begin
            r_acc   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_setup <= '0;
            r_hcnt  <= '0;
            r_step  <= 1'b0;
        end else begin
            if (r_state == S_LOAD) begin
                r_dir   <= w_hdir;
                r_setup <= (w_hdir != r_dir) ? SW'(DIR_SETUP) : '0;
                r_rem   <= w_hsteps;
                r_inc   <= w_hinc;
                r_acc   <= '0;
                r_div   <= '0;
            end
            if (r_state == S_SETUP && r_setup != '0) begin
                r_setup <= r_setup - SW'(1);
            end
            if (r_state == S_RUN) begin
                r_div <= w_tick ? '0 : r_div + DW'(1);
            end
            if (w_adv) begin
                r_acc <= w_sum[ACC_W-1:0];
                r_inc <= w_inc_nx;
            end
            // A carry during a live pulse still counts and stretches it
            if (w_carry) begin
                r_step <= 1'b1;
                r_hcnt <= HW'(STEP_HIGH);
                r_rem  <= r_rem - CNT_W'(1);
                if (r_step) r_ovr <= 1'b1;
            end else if (r_step) begin
                if (r_hcnt == HW'(1)) r_step <= 1'b0;
                r_hcnt <= r_hcnt - HW'(1);
            end
        end
    end

endmodule

// File: tb/tb_move_dda.sv
// Scoreboard bench for move_dda: expected per-move pulse stats are queued at
// acceptance and compared by a step monitor on each move_done.
module tb_move_dda;

    typedef struct {
        int rises;
        int hi;
        int period;
        bit accel;
        bit dir;
        int acc_cyc;
        bit chk_lat;
    } exp_t;

    logic        CLK = 1'b0;
    logic        resetn = 1'b0;
    logic        move_valid = 1'b0;
    logic        move_dir = 1'b0;
    logic [31:0] move_steps = '0;
    logic [31:0] move_inc = '0;
`ifdef ACCEL_EN
    logic [31:0] move_incinc = '0;
`endif
    logic        halt = 1'b0;
    logic        move_ready;
    logic        step;
    logic        dir;
    logic        busy;
    logic        move_done;
    logic        buffer_dtr;
    logic        overrun;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rises = 0;
    int   hi = 0;
    int   stamps[$];
    int   dchg = 0;
    logic pstep = 1'b0;
    logic pdir = 1'b0;
    bit   want_busy = 0;
    exp_t sb[$];
    exp_t e;
    bit   w1, w2, w3;

    move_dda dut (
        .CLK        (CLK),
        .resetn     (resetn),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move_dir   (move_dir),
        .move_steps (move_steps),
        .move_inc   (move_inc),
`ifdef ACCEL_EN
        .move_incinc(move_incinc),
`endif
        .halt       (halt),
        .step       (step),
        .dir        (dir),
        .busy       (busy),
        .move_done  (move_done),
        .buffer_dtr (buffer_dtr),
        .overrun    (overrun)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    task automatic chk(input string tag, input longint got, input longint expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    always @(negedge CLK) begin
        if (want_busy) begin
            chk("b2b_busy", busy, 1);
            want_busy = 0;
        end
        if (dir !== pdir) dchg = cyc;
        pdir = dir;
        if (!busy) begin
            rises = 0;
            hi = 0;
            stamps.delete();
        end else begin
            if (step && !pstep) begin
                rises++;
                stamps.push_back(cyc);
                chk("dir_setup", (cyc - dchg) >= 2, 1);
            end
            if (step) hi++;
        end
        pstep = step;
        if (move_done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rises", rises, e.rises);
                chk("high_cycles", hi, e.hi);
                chk("dir", dir, e.dir);
                if (e.period > 0)
                    for (int i = 1; i < stamps.size(); i++)
                        chk("period", stamps[i] - stamps[i-1], e.period);
                if (e.accel)
                    for (int i = 2; i < stamps.size(); i++)
                        chk("accel_gap",
                            (stamps[i] - stamps[i-1]) < (stamps[i-1] - stamps[i-2]), 1);
                if (e.chk_lat) chk("done_latency", cyc - e.acc_cyc, 3);
                want_busy = (sb.size() > 0);
            end
            rises = 0;
            hi = 0;
            stamps.delete();
        end
    end

    task automatic send(input bit d, input int n, input logic [31:0] inc,
                        input logic [31:0] ii, input int rx, input int hx,
                        input int per, output bit waited);
        int t;
        exp_t x;
        @(negedge CLK);
        move_valid = 1'b1;
        move_dir   = d;
        move_steps = n;
        move_inc   = inc;
`ifdef ACCEL_EN
        move_incinc = ii;
`endif
        waited = 0;
        t = 0;
        while (!move_ready && t < 500) begin
            waited = 1;
            t++;
            @(negedge CLK);
        end
        if (!move_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            x.rises   = rx;
            x.hi      = hx;
            x.period  = per;
            x.accel   = (ii != 0);
            x.dir     = d;
            x.acc_cyc = cyc;
            x.chk_lat = (n == 0);
            sb.push_back(x);
        end
        @(posedge CLK);
        #1 move_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 5000) begin
            @(negedge CLK);
            t++;
        end
        chk("drain", sb.size(), 0);
        repeat (3) @(negedge CLK);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge CLK);
        chk("rst_step", step, 0);
        chk("rst_dir", dir, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", move_done, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_ready", move_ready, 0);
        resetn = 1'b1;
        @(negedge CLK);
        chk("ready_after_rst", move_ready, 1);
        chk("dtr_after_rst", buffer_dtr, 1);

        send(1, 4, 32'h2000_0000, 0, 4, 16, 8, w1);
        drain();
        chk("no_ovr", overrun, 0);

        send(0, 3, 32'h2000_0000, 0, 3, 12, 8, w1);
        send(1, 2, 32'h2000_0000, 0, 2, 8, 8, w2);
        send(0, 5, 32'h2000_0000, 0, 5, 20, 8, w3);
        chk("second_no_wait", w2, 0);
        chk("third_waited", w3, 1);
        drain();

        send(1, 0, 32'h2000_0000, 0, 0, 0, 0, w1);
        drain();

        send(0, 10, 32'h2000_0000, 0, 10, 40, 8, w1);
        send(1, 10, 32'h2000_0000, 0, 10, 40, 8, w2);
        t = 0;
        while (rises < 2 && t < 500) begin
            @(negedge CLK);
            t++;
        end
        chk("halt_reach_step2", rises >= 2, 1);
        halt = 1'b1;
        sb.delete();
        @(negedge CLK);
        chk("halt_step", step, 0);
        chk("halt_busy", busy, 0);
        chk("halt_ready_blocked", move_ready, 0);
        chk("halt_dir_hold", dir, 0);
        halt = 1'b0;
        @(negedge CLK);
        chk("ready_after_halt", move_ready, 1);
        repeat (20) @(negedge CLK);
        chk("flushed_busy", busy, 0);
        chk("flushed_step", step, 0);

        chk("ovr_pre", overrun, 0);
        send(1, 6, 32'h8000_0000, 0, 1, 14, 0, w1);
        drain();
        chk("ovr_set", overrun, 1);
        send(0, 2, 32'h2000_0000, 0, 2, 8, 8, w1);
        drain();
        chk("ovr_hold", overrun, 1);

`ifdef ACCEL_EN
        send(1, 3, 32'h0, 32'h0100_0000, 3, 12, 0, w1);
        drain();
`endif

        send(1, 10, 32'h2000_0000, 0, 10, 40, 8, w1);
        repeat (20) @(negedge CLK);
        resetn = 1'b0;
        sb.delete();
        @(negedge CLK);
        chk("midrst_step", step, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_dir", dir, 0);
        chk("midrst_ovr", overrun, 0);
        resetn = 1'b1;
        repeat (2) @(negedge CLK);
        chk("midrst_ready", move_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
